// File: rtl/ir_cond_unit_pkg.sv
// Shared definitions for the IR / NZCV condition unit:
// condition codes, decode-vector bit positions, NZCV bit positions.
package ir_cond_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLG_COND = 8;
    localparam int FLG_BR   = 7;
    localparam int FLG_MEM  = 6;
    localparam int FLG_I    = 5;
    localparam int FLG_OP   = 1;
    localparam int FLG_SL   = 0;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    localparam logic [31:0] RESET_IR_DEF = 32'hE1A0_0000;

    function automatic logic is_undef(input logic [31:0] w);
        return w[27:26] == 2'b11;
    endfunction

endpackage

// File: rtl/ir_cond_unit_if.sv
// Bus between the multicycle signal unit (master) and the
// IR / NZCV condition unit (slave).
interface ir_cond_unit_if #(
    parameter int CNT_W = 16
);
    logic             IRwrite;
    logic [31:0]      mem_rdata;
    logic             NZCVwrite;
    logic [3:0]       alu_nzcv;
    logic [11:0]      flags;
    logic             zero;
    logic [31:0]      ir;
    logic [3:0]       nzcv;
    logic [CNT_W-1:0] retired;
    logic             undef;

    modport master (
        output IRwrite, mem_rdata, NZCVwrite, alu_nzcv,
        input  flags, zero, ir, nzcv, retired, undef
    );

    modport slave (
        input  IRwrite, mem_rdata, NZCVwrite, alu_nzcv,
        output flags, zero, ir, nzcv, retired, undef
    );
endinterface

// File: rtl/ir_cond_unit_cond_eval.sv
// Condition base evaluator: cond[3:1] and NZCV to the un-inverted
// pass bit; the consumer applies cond[0].
module ir_cond_unit_cond_eval
    import ir_cond_unit_pkg::*;
(
    input  logic [2:0] cond_hi_i,
    input  logic [3:0] nzcv_i,
    output logic       zero_o
);
    logic n, z, c, v;

    assign n = nzcv_i[NZCV_N];
    assign z = nzcv_i[NZCV_Z];
    assign c = nzcv_i[NZCV_C];
    assign v = nzcv_i[NZCV_V];

    always_comb begin
        zero_o = 1'b1;
        unique case (cond_hi_i)
            3'b000: zero_o = z;
            3'b001: zero_o = c;
            3'b010: zero_o = n;
            3'b011: zero_o = v;
            3'b100: zero_o = c & ~z;
            3'b101: zero_o = (n == v);
            3'b110: zero_o = ~z & (n == v);
            3'b111: zero_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/ir_cond_unit.sv
// Instruction register, NZCV register, retired counter and sticky
// undefined flag, plus the decode vector fed to the signal unit.
module ir_cond_unit
    import ir_cond_unit_pkg::*;
#(
    parameter logic [31:0] RESET_IR = RESET_IR_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    ir_cond_unit_if.slave     bus
);
    logic [31:0]      ir_q, ir_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             undef_q, undef_d;
    logic [11:0]      flags_w;

    always_comb begin
        ir_d    = ir_q;
        nzcv_d  = nzcv_q;
        ret_d   = ret_q;
        undef_d = undef_q;
        if (bus.IRwrite) begin
            ir_d    = bus.mem_rdata;
            ret_d   = ret_q + CNT_W'(1);
            undef_d = undef_q | is_undef(bus.mem_rdata);
        end
        if (bus.NZCVwrite) begin
            nzcv_d = bus.alu_nzcv;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q    <= RESET_IR;
            nzcv_q  <= 4'b0000;
            ret_q   <= '0;
            undef_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            nzcv_q  <= nzcv_d;
            ret_q   <= ret_d;
            undef_q <= undef_d;
        end
    end

    // Decode fields come only from the registered IR.
    assign flags_w[FLG_COND+:4] = ir_q[31:28];
    assign flags_w[FLG_BR]      = (ir_q[27:25] == 3'b101);
    assign flags_w[FLG_MEM]     = (ir_q[27:26] == 2'b01);
    assign flags_w[FLG_I]       = ir_q[25];
    assign flags_w[FLG_OP+:4]   = ir_q[24:21];
    assign flags_w[FLG_SL]      = ir_q[20];

    ir_cond_unit_cond_eval u_cond (
        .cond_hi_i (ir_q[31:29]),
        .nzcv_i    (nzcv_q),
        .zero_o    (bus.zero)
    );

    assign bus.flags   = flags_w;
    assign bus.ir      = ir_q;
    assign bus.nzcv    = nzcv_q;
    assign bus.retired = ret_q;
    assign bus.undef   = undef_q;
endmodule

// File: tb/tb_ir_cond_unit.sv
// Directed bench for ir_cond_unit with hand-computed expectations.
module tb_ir_cond_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [3:0] exp_ret = 4'd0;
    logic [3:0] ret_save;

    always #5 clk = ~clk;

    ir_cond_unit_if #(.CNT_W(4)) bus ();

    ir_cond_unit #(
        .RESET_IR (32'hE1A0_0000),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] v_ir [16] = '{
        32'h0A000000, 32'h0A000000, 32'h1A000000, 32'h2A000000,
        32'h2A000000, 32'h4A000000, 32'h4A000000, 32'h6A000000,
        32'h8A000000, 32'h8A000000, 32'hBA000000, 32'hBA000000,
        32'hCA000000, 32'hCA000000, 32'hCA000000, 32'hEA000000
    };
    logic [3:0] v_nz [16] = '{
        4'b0100, 4'b1011, 4'b0100, 4'b0010,
        4'b1101, 4'b1000, 4'b0111, 4'b0001,
        4'b0010, 4'b0110, 4'b1000, 4'b1001,
        4'b0000, 4'b0100, 4'b1000, 4'b0000
    };
    logic v_zero [16] = '{
        1'b1, 1'b0, 1'b1, 1'b1,
        1'b0, 1'b1, 1'b0, 1'b1,
        1'b1, 1'b0, 1'b0, 1'b1,
        1'b1, 1'b0, 1'b0, 1'b1
    };

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] w);
        bus.IRwrite   = 1'b1;
        bus.mem_rdata = w;
        tick();
        bus.IRwrite   = 1'b0;
        exp_ret       = exp_ret + 4'd1;
    endtask

    task automatic set_nzcv(input logic [3:0] f);
        bus.NZCVwrite = 1'b1;
        bus.alu_nzcv  = f;
        tick();
        bus.NZCVwrite = 1'b0;
    endtask

    initial begin
        bus.IRwrite   = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.NZCVwrite = 1'b0;
        bus.alu_nzcv  = 4'h0;

        #12;
        chk("ir_in_reset", bus.ir, 32'hE1A00000);
        chk("ret_in_reset", 32'(bus.retired), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        chk("rst_ir", bus.ir, 32'hE1A00000);
        chk("rst_flags", 32'(bus.flags), 32'hE1A);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_ret", 32'(bus.retired), 32'd0);
        chk("rst_undef", 32'(bus.undef), 32'd0);
        chk("rst_nzcv", 32'(bus.nzcv), 32'd0);

        load_ir(32'hEA000004);
        chk("b_flags", 32'(bus.flags), 32'hEA0);
        chk("b_ret", 32'(bus.retired), 32'd1);
        chk("b_zero", 32'(bus.zero), 32'd1);

        load_ir(32'hE5912004);
        chk("ldr_flags", 32'(bus.flags), 32'hE59);
        load_ir(32'hE0910002);
        chk("adds_flags", 32'(bus.flags), 32'hE09);

        bus.mem_rdata = 32'h12345678;
        tick();
        chk("ir_hold", bus.ir, 32'hE0910002);

        for (int i = 0; i < 16; i++) begin
            set_nzcv(v_nz[i]);
            load_ir(v_ir[i]);
            chk($sformatf("cond%0d", i), 32'(bus.zero), 32'(v_zero[i]));
        end
        chk("lt_cond", 32'(bus.flags[11:8]), 32'hE);

        set_nzcv(4'b0100);
        load_ir(32'h1A000000);
        chk("bne_zero", 32'(bus.zero), 32'd1);
        chk("bne_cond", 32'(bus.flags[11:8]), 32'h1);
        bus.alu_nzcv = 4'b0000;
        tick();
        chk("nzcv_hold", 32'(bus.nzcv), 32'h4);
        chk("zero_reg", 32'(bus.zero), 32'd1);

        chk("undef_clr", 32'(bus.undef), 32'd0);
        load_ir(32'hEC000000);
        chk("undef_set", 32'(bus.undef), 32'd1);
        load_ir(32'hE1A00000);
        chk("undef_stk", 32'(bus.undef), 32'd1);

        bus.IRwrite   = 1'b1;
        bus.mem_rdata = 32'hC0000000;
        bus.NZCVwrite = 1'b1;
        bus.alu_nzcv  = 4'b1001;
        tick();
        bus.IRwrite   = 1'b0;
        bus.NZCVwrite = 1'b0;
        exp_ret       = exp_ret + 4'd1;
        chk("sim_ir", bus.ir, 32'hC0000000);
        chk("sim_nzcv", 32'(bus.nzcv), 32'h9);
        chk("sim_zero", 32'(bus.zero), 32'd1);

        chk("ret_model", 32'(bus.retired), 32'(exp_ret));
        ret_save = exp_ret;
        for (int i = 0; i < 16; i++) begin
            load_ir(32'hE1A00000);
        end
        chk("ret_wrap", 32'(bus.retired), 32'(ret_save));

        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_ir", bus.ir, 32'hE1A00000);
        chk("ar_undef", 32'(bus.undef), 32'd0);
        chk("ar_ret", 32'(bus.retired), 32'd0);
        chk("ar_nzcv", 32'(bus.nzcv), 32'd0);
        chk("ar_flags", 32'(bus.flags), 32'hE1A);
        @(negedge clk);
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
